ysyx_22040237_lsu: RTL and testbench
====================================

YSYX_22040237_LSU -- requirements
Module: ysyx_22040237_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 64, the register/address width.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-004 SHALL have port in_valid_i  input  1  execute stage result valid.
REQ-005 SHALL have port in_ready_o  output  1  LSU can accept a new operation.
REQ-006 SHALL have port ls_info_i  input  5  operation: [0] load, [1] store, [3:2] size (00 B, 01 H, 10 W, 11 D), [4] unsigned load.
REQ-007 SHALL have port addr_i  input  XLEN  ALU result: the effective address for memory operations, the writeback value otherwise.
REQ-008 SHALL have port wdata_i  input  XLEN  store data (rs2).
REQ-009 SHALL have ports rd_wr_en_i  input  1  and rd_idx_i  input  5  for the destination register.
REQ-010 SHALL have memory ports: mem_req_o (1) out; mem_we_o (1) out; mem_addr_o (XLEN, 8-byte aligned) out; mem_wdata_o (64) out; mem_wmask_o (8) out; mem_gnt_i (1) in; mem_rvalid_i (1) in; mem_rdata_i (64) in.
REQ-011 SHALL have writeback ports: out_valid_o (1) out; out_ready_i (1) in; rd_wr_en_o (1) out; rd_idx_o (5) out; rd_data_o (XLEN) out; misalign_o (1) out.

Function
REQ-012 SHALL implement the FSM IDLE -> REQ -> WAIT_R -> DONE; in_ready_o = (state==IDLE).
REQ-013 SHALL accept an operation when in_valid_i && in_ready_o, capturing all inputs into registers.
REQ-014 SHALL route a non-memory op (load=store=0) IDLE->DONE, with rd_data_o = addr_i and out_valid_o asserted the next cycle (latency 1).
REQ-015 SHALL treat ls_info_i with load and store both set as a non-memory op.
REQ-016 SHALL flag misalignment when the address is not a multiple of the access size; the op then goes IDLE->DONE with no mem_req_o, misalign_o=1 and rd_wr_en_o=0.
REQ-017 SHALL, in REQ, hold mem_req_o=1 and all other mem_* outputs stable until mem_gnt_i.
REQ-018 SHALL set mem_addr_o = {addr[XLEN-1:3], 3'b0}, and for a store place the data at byte lane addr[2:0] with the matching size mask (B=1, H=3, W=0xF, D=0xFF shifted left by addr[2:0]).
REQ-019 SHALL move a store REQ->DONE on mem_gnt_i, with rd_wr_en_o forced to 0.
REQ-020 SHALL move a load REQ->WAIT_R on mem_gnt_i, then to DONE on mem_rvalid_i.
REQ-021 SHALL extract the load data by shifting mem_rdata_i right by 8*addr[2:0], then sign- or zero-extend (zero-extend if [4]) from the access size.
REQ-022 SHALL register the load result, so out_valid_o asserts the cycle after mem_rvalid_i.
REQ-023 SHALL ignore mem_rvalid_i outside WAIT_R, and mem_gnt_i outside REQ.
REQ-024 SHALL, in DONE, hold out_valid_o and all writeback outputs stable until out_ready_i, then return to IDLE.
REQ-025 SHALL accept no new op in the DONE-exit cycle (no bypass).
REQ-026 SHALL drive rd_data_o with the full XLEN value when the size is D, with no extension.

Reset
REQ-027 SHALL, while rst=0 at a clock edge, force state=IDLE, out_valid_o=0, mem_req_o=0, mem_we_o=0, misalign_o=0, rd_wr_en_o=0, rd_idx_o=0, rd_data_o=0, mem_addr_o=0, mem_wdata_o=0 and mem_wmask_o=0.
REQ-028 SHALL abandon any outstanding operation on reset mid-operation, ignore a late mem_rvalid_i, and leave in_ready_o=1 in the first cycle after rst goes high.

Structure
REQ-029 SHALL take the ls_info bit positions, size encodings and FSM state encodings from the shared ysyx_22040237 defines include, alongside the EXU_INFO defines.
REQ-030 SHALL place store lane alignment and load extraction/extension in one combinational sub-module, ysyx_22040237_lsu_align.

Verification
REQ-031 SHALL be checked with a non-memory op, addr_i=0x1234 and rd_idx 5: out_valid_o one cycle later with rd_data_o=0x1234, rd_wr_en_o=1 and no mem_req_o.
REQ-032 SHALL be checked with a store of size H to addr 0x8000_0006, wdata 0xBEEF and gnt after 3 cycles: mem_addr_o=0x8000_0000, mem_wmask_o=0xC0, mem_wdata_o[63:48]=0xBEEF, stable while waiting, and rd_wr_en_o=0.
REQ-033 SHALL be checked with a signed byte load from 0x...03 and rdata 0x0000_0000_8000_0000: rd_data_o=0xFFFF_FFFF_FFFF_FF80; the same as unsigned gives 0x80.
REQ-034 SHALL be checked with a word load from 0x...02: misalign_o=1, no mem_req_o, rd_wr_en_o=0 and out_valid_o after 1 cycle.
REQ-035 SHALL be checked with out_ready_i=0 for 4 cycles in DONE: outputs hold, in_ready_o=0 throughout, and IDLE is reached the cycle after out_ready_i=1.
REQ-036 SHALL be checked with rst=0 asserted in WAIT_R and a stray rvalid afterwards: IDLE with all outputs 0, and no out_valid_o.

Source files
------------

// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared definitions for the load/store unit: ls_info bit positions,
// access size encodings, FSM state encoding and small decode helpers.
package ysyx_22040237_lsu_pkg;

    localparam int LS_LOAD     = 0;
    localparam int LS_STORE    = 1;
    localparam int LS_SIZE_LSB = 2;
    localparam int LS_UNSIGNED = 4;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_t;

    // An access is misaligned when the byte offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            SIZE_W:  return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Byte-lane steering for the LSU: places store data and its byte mask on
// the lanes selected by the address offset, and pulls load data back out
// of the 64-bit memory word with sign or zero extension.
module ysyx_22040237_lsu_align
    import ysyx_22040237_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      st_size,
    input  logic [2:0]      st_offset,
    input  logic [63:0]     st_data,
    output logic [63:0]     st_lane_data,
    output logic [7:0]      st_lane_mask,
    input  logic [1:0]      ld_size,
    input  logic [2:0]      ld_offset,
    input  logic            ld_unsigned,
    input  logic [63:0]     ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [63:0] shifted;
    logic [63:0] extended;

    // Store path: shift data and size mask up to the addressed byte lane.
    always_comb begin
        st_lane_data = st_data << {st_offset, 3'b000};
        st_lane_mask = size_mask(st_size) << st_offset;
    end

    // Load path: bring the addressed bytes down to bit 0, then extend from the access size.
    always_comb begin
        shifted  = ld_rdata >> {ld_offset, 3'b000};
        extended = shifted;
        case (ld_size)
            SIZE_B:  extended = ld_unsigned ? {56'b0, shifted[7:0]}
                                            : {{56{shifted[7]}}, shifted[7:0]};
            SIZE_H:  extended = ld_unsigned ? {48'b0, shifted[15:0]}
                                            : {{48{shifted[15]}}, shifted[15:0]};
            SIZE_W:  extended = ld_unsigned ? {32'b0, shifted[31:0]}
                                            : {{32{shifted[31]}}, shifted[31:0]};
            default: extended = shifted;
        endcase
        ld_data = XLEN'(extended);
    end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: accepts one execute-stage result at a time, performs the
// memory request/response handshake for loads and stores, and presents a
// registered writeback record until the consumer takes it.
module ysyx_22040237_lsu
    import ysyx_22040237_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      ls_info_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            rd_wr_en_i,
    input  logic [4:0]      rd_idx_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [63:0]     mem_wdata_o,
    output logic [7:0]      mem_wmask_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [63:0]     mem_rdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            rd_wr_en_o,
    output logic [4:0]      rd_idx_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            misalign_o
);

    lsu_state_t      state;
    lsu_state_t      state_next;
    logic            accept;
    logic            is_load;
    logic            is_store;
    logic            misaligned;
    logic            go_mem;
    logic [1:0]      in_size;
    logic            op_load;
    logic            op_unsigned;
    logic [1:0]      op_size;
    logic [2:0]      op_offset;
    logic            op_rd_wr_en;
    logic [63:0]     st_lane_data;
    logic [7:0]      st_lane_mask;
    logic [XLEN-1:0] ld_data;

    ysyx_22040237_lsu_align #(.XLEN(XLEN)) u_align (
        .st_size      (in_size),
        .st_offset    (addr_i[2:0]),
        .st_data      (64'(wdata_i)),
        .st_lane_data (st_lane_data),
        .st_lane_mask (st_lane_mask),
        .ld_size      (op_size),
        .ld_offset    (op_offset),
        .ld_unsigned  (op_unsigned),
        .ld_rdata     (mem_rdata_i),
        .ld_data      (ld_data)
    );

    // Decode the incoming op; load and store together count as a plain ALU result.
    always_comb begin
        in_ready_o = (state == ST_IDLE);
        accept     = in_valid_i && in_ready_o;
        is_load    = ls_info_i[LS_LOAD] && !ls_info_i[LS_STORE];
        is_store   = ls_info_i[LS_STORE] && !ls_info_i[LS_LOAD];
        in_size    = ls_info_i[LS_SIZE_LSB +: 2];
        misaligned = (is_load || is_store) && is_misaligned(in_size, addr_i[2:0]);
        go_mem     = (is_load || is_store) && !misaligned;
    end

    // Next-state logic: memory ops go through REQ, everything else straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept)       state_next = go_mem ? ST_REQ : ST_DONE;
            ST_REQ:    if (mem_gnt_i)    state_next = op_load ? ST_WAIT_R : ST_DONE;
            ST_WAIT_R: if (mem_rvalid_i) state_next = ST_DONE;
            ST_DONE:   if (out_ready_i)  state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Datapath registers: capture the op, drive the memory request and build the writeback record.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_load     <= 1'b0;
            op_unsigned <= 1'b0;
            op_size     <= SIZE_B;
            op_offset   <= 3'b0;
            op_rd_wr_en <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            out_valid_o <= 1'b0;
            rd_wr_en_o  <= 1'b0;
            rd_idx_o    <= '0;
            rd_data_o   <= '0;
            misalign_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_load     <= is_load;
                        op_unsigned <= ls_info_i[LS_UNSIGNED];
                        op_size     <= in_size;
                        op_offset   <= addr_i[2:0];
                        op_rd_wr_en <= rd_wr_en_i;
                        rd_idx_o    <= rd_idx_i;
                        misalign_o  <= misaligned;
                        if (go_mem) begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= is_store;
                            mem_addr_o  <= {addr_i[XLEN-1:3], 3'b000};
                            mem_wdata_o <= is_store ? st_lane_data : 64'b0;
                            mem_wmask_o <= is_store ? st_lane_mask : 8'b0;
                        end else begin
                            out_valid_o <= 1'b1;
                            rd_wr_en_o  <= misaligned ? 1'b0 : rd_wr_en_i;
                            rd_data_o   <= misaligned ? '0 : addr_i;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_wmask_o <= 8'b0;
                        if (!op_load) begin
                            out_valid_o <= 1'b1;
                            rd_wr_en_o  <= 1'b0;
                            rd_data_o   <= '0;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid_i) begin
                        out_valid_o <= 1'b1;
                        rd_wr_en_o  <= op_rd_wr_en;
                        rd_data_o   <= ld_data;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) out_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Self-checking bench for the LSU: a table of operations with expected memory
// requests and writeback records, a scoreboard queue of pending results, and
// hand-written sequences for back-pressure, no-bypass and mid-operation reset.
module tb_ysyx_22040237_lsu;

    typedef struct {
        logic [4:0]  info;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [4:0]  rd_idx;
        logic        wr_en;
        int          gnt_delay;
        bit          stray;
        int          hold;
        bit          exp_req;
        logic [63:0] exp_addr;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_wdata;
        bit          chk_data;
        logic [63:0] exp_rd_data;
        logic        exp_wr_en;
        logic        exp_mis;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  ls_info_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        rd_wr_en_i;
    logic [4:0]  rd_idx_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        rd_wr_en_o;
    logic [4:0]  rd_idx_o;
    logic [63:0] rd_data_o;
    logic        misalign_o;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t vecs[NVEC];
    vec_t sb_q[$];

    ysyx_22040237_lsu #(.XLEN(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .ls_info_i    (ls_info_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rd_wr_en_i   (rd_wr_en_i),
        .rd_idx_i     (rd_idx_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .rd_wr_en_o   (rd_wr_en_o),
        .rd_idx_o     (rd_idx_o),
        .rd_data_o    (rd_data_o),
        .misalign_o   (misalign_o)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic vec_t mkv(
        input logic [4:0] info, input logic [63:0] addr, input logic [63:0] wdata,
        input logic [63:0] rdata, input logic [4:0] rd_idx, input logic wr_en,
        input int gnt_delay, input bit stray, input int hold,
        input bit exp_req, input logic [63:0] exp_addr, input logic [7:0] exp_wmask,
        input logic [63:0] exp_wdata, input bit chk_data, input logic [63:0] exp_rd_data,
        input logic exp_wr_en, input logic exp_mis, input int exp_lat);
        vec_t v;
        v.info = info; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rd_idx = rd_idx; v.wr_en = wr_en; v.gnt_delay = gnt_delay; v.stray = stray;
        v.hold = hold; v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_wmask = exp_wmask;
        v.exp_wdata = exp_wdata; v.chk_data = chk_data; v.exp_rd_data = exp_rd_data;
        v.exp_wr_en = exp_wr_en; v.exp_mis = exp_mis; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] m);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        in_valid_i = 1'b1;
        ls_info_i  = v.info;
        addr_i     = v.addr;
        wdata_i    = v.wdata;
        rd_wr_en_i = v.wr_en;
        rd_idx_i   = v.rd_idx;
        sb_q.push_back(v);
        @(posedge clk);
        #1 in_valid_i = 1'b0;
    endtask

    task automatic checkOutput(input int idx, input int cyc);
        vec_t e;
        if (sb_q.size() == 0) begin
            cmp($sformatf("v%0d_scoreboard_empty", idx), 64'(sb_q.size()), 64'd1);
            return;
        end
        e = sb_q.pop_front();
        cmp($sformatf("v%0d_rd_idx", idx), 64'(rd_idx_o), 64'(e.rd_idx));
        cmp($sformatf("v%0d_rd_wr_en", idx), 64'(rd_wr_en_o), 64'(e.exp_wr_en));
        cmp($sformatf("v%0d_misalign", idx), 64'(misalign_o), 64'(e.exp_mis));
        if (e.chk_data) cmp($sformatf("v%0d_rd_data", idx), rd_data_o, e.exp_rd_data);
        if (e.exp_lat > 0) cmp($sformatf("v%0d_latency", idx), 64'(cyc), 64'(e.exp_lat));
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        bit done = 0, saw_req = 0, granted = 0, rv_sent = 0, expect_out = 0;
        int req_cycles = 0;
        applyStimulus(v);
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (expect_out) begin
                cmp($sformatf("v%0d_rvalid_to_out", idx), 64'(out_valid_o), 64'd1);
                expect_out = 0;
            end
            if (out_valid_o) begin
                checkOutput(idx, cyc);
                for (int h = 0; h < v.hold; h++) begin
                    @(negedge clk);
                    cmp($sformatf("v%0d_hold%0d_valid", idx, h), 64'(out_valid_o), 64'd1);
                    cmp($sformatf("v%0d_hold%0d_data", idx, h), rd_data_o, v.exp_rd_data);
                    cmp($sformatf("v%0d_hold%0d_in_ready", idx, h), 64'(in_ready_o), 64'd0);
                end
                cmp($sformatf("v%0d_done_in_ready", idx), 64'(in_ready_o), 64'd0);
                out_ready_i = 1'b1;
                in_valid_i  = 1'b1;
                ls_info_i   = 5'b0;
                addr_i      = 64'hDEAD;
                @(negedge clk);
                out_ready_i = 1'b0;
                in_valid_i  = 1'b0;
                cmp($sformatf("v%0d_idle_after_ready", idx), 64'(in_ready_o), 64'd1);
                cmp($sformatf("v%0d_valid_dropped", idx), 64'(out_valid_o), 64'd0);
                done = 1;
            end else if (mem_req_o) begin
                saw_req = 1;
                cmp($sformatf("v%0d_req%0d_addr", idx, req_cycles), mem_addr_o, v.exp_addr);
                cmp($sformatf("v%0d_req%0d_we", idx, req_cycles), 64'(mem_we_o), 64'(v.info[1]));
                if (v.info[1]) begin
                    cmp($sformatf("v%0d_req%0d_wmask", idx, req_cycles), 64'(mem_wmask_o), 64'(v.exp_wmask));
                    cmp($sformatf("v%0d_req%0d_wdata", idx, req_cycles),
                        mem_wdata_o & byte_mask(v.exp_wmask), v.exp_wdata & byte_mask(v.exp_wmask));
                end
                if (req_cycles == v.gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    granted = 1;
                end else if (v.stray) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = '1;
                end
                req_cycles++;
            end else if (granted && v.info[0] && !rv_sent) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = v.rdata;
                rv_sent = 1;
                expect_out = 1;
            end
        end
        cmp($sformatf("v%0d_saw_req", idx), 64'(saw_req), 64'(v.exp_req));
        if (!done) begin
            cmp($sformatf("v%0d_timeout", idx), 64'd0, 64'd1);
            sb_q.delete();
            do_reset();
        end
    endtask

    initial begin
        rst = 1'b0; in_valid_i = 1'b0; ls_info_i = '0; addr_i = '0; wdata_i = '0;
        rd_wr_en_i = 1'b0; rd_idx_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = '0; out_ready_i = 1'b0;

        vecs[0]  = mkv(5'b00000, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 0, 0, 0,
                       0, 64'h0, 8'h00, 64'h0, 1, 64'h1234, 1'b1, 1'b0, 1);
        vecs[1]  = mkv(5'b00011, 64'hCAFE, 64'h55, 64'h0, 5'd7, 1'b1, 0, 0, 0,
                       0, 64'h0, 8'h00, 64'h0, 1, 64'hCAFE, 1'b1, 1'b0, 1);
        vecs[2]  = mkv(5'b00110, 64'h8000_0006, 64'hBEEF, 64'h0, 5'd3, 1'b1, 3, 1, 0,
                       1, 64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 0, 64'h0, 1'b0, 1'b0, 0);
        vecs[3]  = mkv(5'b00001, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd10, 1'b1, 0, 0, 0,
                       1, 64'h8000_0000, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 0);
        vecs[4]  = mkv(5'b10001, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd11, 1'b1, 0, 0, 0,
                       1, 64'h8000_0000, 8'h00, 64'h0, 1, 64'h80, 1'b1, 1'b0, 0);
        vecs[5]  = mkv(5'b01001, 64'h8000_0002, 64'h0, 64'h0, 5'd12, 1'b1, 0, 0, 0,
                       0, 64'h0, 8'h00, 64'h0, 0, 64'h0, 1'b0, 1'b1, 1);
        vecs[6]  = mkv(5'b01110, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd13, 1'b1, 1, 0, 0,
                       1, 64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 1'b0, 1'b0, 0);
        vecs[7]  = mkv(5'b01101, 64'h8000_0008, 64'h0, 64'hFEDC_BA98_7654_3210, 5'd14, 1'b1, 0, 0, 0,
                       1, 64'h8000_0008, 8'h00, 64'h0, 1, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 0);
        vecs[8]  = mkv(5'b01001, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000, 5'd15, 1'b1, 1, 0, 4,
                       1, 64'h8000_0000, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_89AB_CDEF, 1'b1, 1'b0, 0);
        vecs[9]  = mkv(5'b10101, 64'h8000_000E, 64'h0, 64'hF00D_0000_0000_0000, 5'd16, 1'b1, 2, 1, 0,
                       1, 64'h8000_0008, 8'h00, 64'h0, 1, 64'h0000_0000_0000_F00D, 1'b1, 1'b0, 0);
        vecs[10] = mkv(5'b00010, 64'h8000_0005, 64'hAA, 64'h0, 5'd17, 1'b1, 0, 0, 0,
                       1, 64'h8000_0000, 8'h20, 64'h0000_AA00_0000_0000, 0, 64'h0, 1'b0, 1'b0, 0);
        vecs[11] = mkv(5'b01010, 64'h8000_0006, 64'h1, 64'h0, 5'd18, 1'b1, 0, 0, 0,
                       0, 64'h0, 8'h00, 64'h0, 0, 64'h0, 1'b0, 1'b1, 1);
        vecs[12] = mkv(5'b00101, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 5'd19, 1'b1, 0, 0, 0,
                       1, 64'h8000_0000, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0, 0);
        vecs[13] = mkv(5'b00001, 64'h8000_0001, 64'h0, 64'h0000_0000_0000_7F00, 5'd20, 1'b0, 0, 0, 0,
                       1, 64'h8000_0000, 8'h00, 64'h0, 1, 64'h7F, 1'b0, 1'b0, 0);

        // Power-on reset: every registered output is zero and the LSU is ready.
        repeat (3) @(negedge clk);
        cmp("rst_in_ready", 64'(in_ready_o), 64'd1);
        cmp("rst_out_valid", 64'(out_valid_o), 64'd0);
        cmp("rst_mem_req", 64'(mem_req_o), 64'd0);
        cmp("rst_rd_data", rd_data_o, 64'd0);
        cmp("rst_mem_wmask", 64'(mem_wmask_o), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) run_vector(i, vecs[i]);
        cmp("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        // Reset while waiting for load data, then a late rvalid that must be ignored.
        @(negedge clk);
        in_valid_i = 1'b1; ls_info_i = 5'b01101; addr_i = 64'h8000_0008;
        rd_wr_en_i = 1'b1; rd_idx_i = 5'd9;
        @(negedge clk);
        in_valid_i = 1'b0;
        cmp("mid_rst_req", 64'(mem_req_o), 64'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        cmp("mid_rst_wait_r", 64'(in_ready_o | mem_req_o | out_valid_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        cmp("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
        cmp("mid_rst_mem_req", 64'(mem_req_o), 64'd0);
        cmp("mid_rst_mem_we", 64'(mem_we_o), 64'd0);
        cmp("mid_rst_mem_addr", mem_addr_o, 64'd0);
        cmp("mid_rst_mem_wdata", mem_wdata_o, 64'd0);
        cmp("mid_rst_rd_idx", 64'(rd_idx_o), 64'd0);
        cmp("mid_rst_rd_wr_en", 64'(rd_wr_en_o), 64'd0);
        cmp("mid_rst_misalign", 64'(misalign_o), 64'd0);
        rst = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h1111_2222_3333_4444;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        cmp("after_rst_in_ready", 64'(in_ready_o), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("after_rst_no_valid%0d", k), 64'(out_valid_o), 64'd0);
            @(negedge clk);
        end
        cmp("after_rst_rd_data", rd_data_o, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
